serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor computing A - B, LSB first.
- Reuses one full-subtractor cell plus a borrow flip-flop.
- Complements the team's combinational full adder: the same single-bit cell runs in the subtract direction and is iterated over WIDTH clock cycles.
- Used where area matters more than latency; a start/done handshake connects it to a controlling FSM.

---
 rtl/serial_subtractor_if.sv | 15 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell plus a borrow
// flop, iterated LSB first over WIDTH cycles to produce A - B and the final borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, a_sr_n;
  logic [WIDTH-1:0] b_sr, b_sr_n;
  logic [WIDTH-1:0] res_sr, res_sr_n;
  logic             br, br_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] diff, diff_n;
  logic             bout, bout_n;
  logic             busy, busy_n;
  logic             done, done_n;

  logic             ai, bi, d, br_next;
  logic [WIDTH-1:0] res_shifted;

  // Full-subtractor cell on the current LSB of each operand.
  always_comb begin
    ai          = a_sr[0];
    bi          = b_sr[0];
    d           = ai ^ bi ^ br;
    br_next     = (~ai & bi) | (~(ai ^ bi) & br);
    res_shifted = {d, res_sr[WIDTH-1:1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_n  = state;
    a_sr_n   = a_sr;
    b_sr_n   = b_sr;
    res_sr_n = res_sr;
    br_n     = br;
    cnt_n    = cnt;
    diff_n   = diff;
    bout_n   = bout;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          a_sr_n   = bus.a;
          b_sr_n   = bus.b;
          res_sr_n = '0;
          br_n     = 1'b0;
          cnt_n    = '0;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_n   = a_sr >> 1;
        b_sr_n   = b_sr >> 1;
        res_sr_n = res_shifted;
        br_n     = br_next;
        cnt_n    = CW'(cnt + CW'(1));
        if (cnt == CW'(WIDTH - 1)) begin
          diff_n  = res_shifted;
          bout_n  = br_next;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == SHIFT);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      a_sr   <= a_sr_n;
      b_sr   <= b_sr_n;
      res_sr <= res_sr_n;
      br     <= br_n;
      cnt    <= cnt_n;
      diff   <= diff_n;
      bout   <= bout_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.diff = diff;
  assign bus.bout = bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of the serial subtractor at WIDTH=8 plus a full WIDTH=4 sweep.
module tb_serial_subtractor;

  localparam int unsigned W8 = 8;
  localparam int unsigned W4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W8)) bus8 ();
  serial_subtractor_if #(.WIDTH(W4)) bus4 ();

  serial_subtractor #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(W4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One operation on the 8-bit unit; result must hold at prev until done.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb,
                     input logic [7:0] prev, input logic prev_b, input bit timing);
    int lat;
    int bc;
    bit held;
    bus8.a = a; bus8.b = b; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b;
    lat = 1; bc = 0; held = 1'b1;
    if (bus8.busy) bc++;
    while (!bus8.done && lat < 40) begin
      if (bus8.diff !== prev || bus8.bout !== prev_b) held = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (bus8.busy) bc++;
    end
    check({tag, " done"}, 64'(bus8.done), 64'd1);
    check({tag, " diff"}, 64'(bus8.diff), 64'(ed));
    check({tag, " bout"}, 64'(bus8.bout), 64'(eb));
    check({tag, " hold"}, 64'(held), 64'd1);
    if (timing) begin
      check({tag, " latency"}, 64'(lat), 64'd9);
      check({tag, " busy_cycles"}, 64'(bc), 64'd8);
    end
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 64'(bus8.done), 64'd0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] prev, input logic prev_b);
    int lat;
    bit held;
    logic [3:0] ed;
    logic eb;
    ed = 4'(a - b);
    eb = (a < b);
    bus4.a = a; bus4.b = b; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0; bus4.a = ~a; bus4.b = ~b;
    lat = 1; held = 1'b1;
    while (!bus4.done && lat < 40) begin
      if (bus4.diff !== prev || bus4.bout !== prev_b) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("sweep %0d-%0d done", a, b), 64'(bus4.done), 64'd1);
    check($sformatf("sweep %0d-%0d diff", a, b), 64'(bus4.diff), 64'(ed));
    check($sformatf("sweep %0d-%0d bout", a, b), 64'(bus4.bout), 64'(eb));
    check($sformatf("sweep %0d-%0d hold", a, b), 64'(held), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int dones;
    logic [3:0] p4;
    logic pb4;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;

    #1;
    check("rst busy", 64'(bus8.busy), 64'd0);
    check("rst done", 64'(bus8.done), 64'd0);
    check("rst diff", 64'(bus8.diff), 64'd0);
    check("rst bout", 64'(bus8.bout), 64'd0);
    check("rst diff4", 64'(bus4.diff), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    op8("t1 200-55", 8'd200, 8'd55, 8'd145, 1'b0, 8'd0, 1'b0, 1'b1);
    op8("t2 55-200", 8'd55, 8'd200, 8'd111, 1'b1, 8'd145, 1'b0, 1'b1);
    op8("t3 0-1", 8'd0, 8'd1, 8'd255, 1'b1, 8'd111, 1'b1, 1'b0);
    op8("t3 a5-a5", 8'hA5, 8'hA5, 8'd0, 1'b0, 8'd255, 1'b1, 1'b0);

    // Re-pulsed start in SHIFT and in DONE, with operands changed, must be ignored.
    bus8.a = 8'd100; bus8.b = 8'd30; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = 8'd5; bus8.b = 8'd200;
    dones = 0;
    for (int i = 1; i <= 14; i++) begin
      bus8.start = (i == 3 || i == 9);
      @(posedge clk); #1;
      if (bus8.done) dones++;
    end
    bus8.start = 1'b0;
    check("t4 done_count", 64'(dones), 64'd1);
    check("t4 diff", 64'(bus8.diff), 64'd70);
    check("t4 bout", 64'(bus8.bout), 64'd0);
    check("t4 idle", 64'(bus8.busy), 64'd0);

    // Asynchronous abort during the fourth SHIFT cycle.
    bus8.a = 8'd9; bus8.b = 8'd3; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5 busy_before", 64'(bus8.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t5 abort busy", 64'(bus8.busy), 64'd0);
    check("t5 abort done", 64'(bus8.done), 64'd0);
    check("t5 abort diff", 64'(bus8.diff), 64'd0);
    check("t5 abort bout", 64'(bus8.bout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5 no_done", 64'(bus8.done), 64'd0);
    op8("t5 9-3", 8'd9, 8'd3, 8'd6, 1'b0, 8'd0, 1'b0, 1'b1);

    p4 = bus4.diff;
    pb4 = bus4.bout;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4(4'(a), 4'(b), p4, pb4);
        p4 = 4'(a - b);
        pb4 = (a < b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
